mem_stage_ctrl: RTL and testbench

- Consumer side of the EX/MEM pipeline register: takes the registered EX/MEM bundle and turns loads and stores into a data-memory request/response transaction.
- Produces aligned, extended load data and a misalignment flag for the MEM/WB register.
- Asserts a stall to the hazard unit while a memory transaction is outstanding.
- Issues exactly one memory request per instruction, however long the pipeline is frozen.

---
 rtl/rv32i_types.sv | 51 +++++
 rtl/load_align.sv | 33 +++
 rtl/mem_stage_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the memory stage.
//   mem_ctrl_state_t    - memory-stage controller states
//   load_funct3_t       - funct3 encodings of the load instructions
//   store_funct3_t      - funct3 encodings of the store instructions
//   ex_mem_pipeline_reg - EX/MEM register fields consumed by the memory stage
//   is_misaligned()     - access-size alignment check shared by loads and stores
package rv32i_types;

  localparam int unsigned Xlen = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StHold
  } mem_ctrl_state_t;

  typedef enum logic [2:0] {
    Lb  = 3'b000,
    Lh  = 3'b001,
    Lw  = 3'b010,
    Lbu = 3'b100,
    Lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    Sb = 3'b000,
    Sh = 3'b001,
    Sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [Xlen-1:0] alu_out;
    logic [Xlen-1:0] rs2_out;
  } ex_mem_pipeline_reg;

  // funct3[1:0] is the access size for both loads and stores: 01 = half, 10 = word.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    logic bad;
    unique case (size)
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
//   funct3 - load type (LB/LH/LW/LBU/LHU)
//   off    - byte offset of the access within the word
//   rdata  - raw word returned by memory
//   data   - lane-shifted, sign/zero-extended load result
module load_align
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = '0;
    unique case (load_funct3_t'(funct3))
      Lb:      data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      Lbu:     data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      Lh:      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      Lhu:     data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      Lw:      data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns the EX/MEM bundle into one data-memory transaction per
// instruction and hands aligned load data to MEM/WB.
//   clk, rst_n      - clock, asynchronous active-low reset
//   ex_mem          - EX/MEM register output
//   advance         - pipeline registers load this cycle
//   dmem_*          - registered memory request (addr/read/write/wmask/wdata), rdata/resp back
//   mem_stall       - freeze the pipeline while a transaction is outstanding
//   load_data       - aligned, extended load result (valid in HOLD, else 0)
//   misaligned      - current access is misaligned; no request is issued
module mem_stage_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ex_mem_pipeline_reg ex_mem,
  input  logic               advance,
  output logic [XLEN-1:0]    dmem_addr,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [3:0]         dmem_wmask,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_resp,
  output logic               mem_stall,
  output logic [XLEN-1:0]    load_data,
  output logic               misaligned
);

  mem_ctrl_state_t state_q, state_d;
  logic            read_q, read_d, write_q, write_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [3:0]      wmask_q, wmask_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;

  logic [1:0]      off;
  logic            mem_op, access;
  logic [3:0]      store_mask;
  logic [XLEN-1:0] aligned;

  assign off        = ex_mem.alu_out[1:0];
  assign mem_op     = ex_mem.valid & (ex_mem.mem_read | ex_mem.mem_write);
  assign misaligned = mem_op & is_misaligned(ex_mem.funct3[1:0], off);
  assign access     = mem_op & ~misaligned;

  always_comb begin
    store_mask = 4'b0000;
    unique case (store_funct3_t'(ex_mem.funct3))
      Sb:      store_mask = 4'b0001 << off;
      Sh:      store_mask = 4'b0011 << off;
      Sw:      store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  end

  // Aligns from the captured funct3/offset so the result does not depend on ex_mem
  // staying frozen during BUSY.
  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .funct3 (funct3_q),
    .off    (off_q),
    .rdata  (dmem_rdata),
    .data   (aligned)
  );

  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    mem_stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_stall = access;
        if (access) begin
          state_d  = StBusy;
          read_d   = ex_mem.mem_read;
          write_d  = ex_mem.mem_write;
          addr_d   = {ex_mem.alu_out[XLEN-1:2], 2'b00};
          wmask_d  = ex_mem.mem_write ? store_mask : 4'b0000;
          wdata_d  = ex_mem.mem_write ? (ex_mem.rs2_out << {off, 3'b000}) : '0;
          funct3_d = ex_mem.funct3;
          off_d    = off;
        end
      end
      StBusy: begin
        // advance is ignored here: the transaction always completes first.
        mem_stall = 1'b1;
        if (dmem_resp) begin
          state_d     = StHold;
          read_d      = 1'b0;
          write_d     = 1'b0;
          load_data_d = read_q ? aligned : '0;
        end
      end
      StHold: begin
        if (advance) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wmask_q     <= 4'b0000;
      wdata_q     <= '0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_addr  = addr_q;
  assign dmem_read  = read_q;
  assign dmem_write = write_q;
  assign dmem_wmask = wmask_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = (state_q == StHold) ? load_data_q : '0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, misalignment, HOLD and reset cases.
module tb_mem_stage_ctrl;
  import rv32i_types::*;

  localparam int unsigned XLEN = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  ex_mem_pipeline_reg ex_mem;
  logic               advance;
  logic [XLEN-1:0]    dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic               dmem_read, dmem_write, dmem_resp, mem_stall, misaligned;
  logic [3:0]         dmem_wmask;

  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .XLEN (XLEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_mem     (ex_mem),
    .advance    (advance),
    .dmem_addr  (dmem_addr),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_stall  (mem_stall),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  function automatic ex_mem_pipeline_reg mk(input logic v, input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
    ex_mem_pipeline_reg b;
    b.valid     = v;
    b.mem_read  = rd;
    b.mem_write = wr;
    b.funct3    = f3;
    b.alu_out   = a;
    b.rs2_out   = d;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The hazard unit must never raise advance while a transaction is in flight.
  always @(posedge clk) begin
    if (rst_n && dut.state_q == StBusy) begin
      checks++;
      assert (advance === 1'b0) passed++;
      else $error("FAIL advance_in_busy: observed %0b expected 0", advance);
    end
  end

  // Single load with a 1-cycle response, then advance out of HOLD.
  task automatic load_txn(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp);
    ex_mem = mk(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
    #1;
    step();
    chk({tag, "_read"}, 32'(dmem_read), 32'd1);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    step();
    chk({tag, "_data"}, load_data, exp);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    advance    = 1'b1;
    step();
    ex_mem  = '0;
    advance = 1'b0;
  endtask

  task automatic store_txn(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_addr,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    ex_mem = mk(1'b1, 1'b0, 1'b1, f3, a, d);
    #1;
    chk({tag, "_stall0"}, 32'(mem_stall), 32'd1);
    step();
    chk({tag, "_write"}, 32'(dmem_write), 32'd1);
    chk({tag, "_read"}, 32'(dmem_read), 32'd0);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_wmask"}, 32'(dmem_wmask), 32'(exp_mask));
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    dmem_resp = 1'b1;
    step();
    chk({tag, "_write_off"}, 32'(dmem_write), 32'd0);
    chk({tag, "_stall_hold"}, 32'(mem_stall), 32'd0);
    chk({tag, "_ldata"}, load_data, 32'h0);
    dmem_resp = 1'b0;
    advance   = 1'b1;
    step();
    ex_mem  = '0;
    advance = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    ex_mem     = '0;
    advance    = 1'b0;
    dmem_rdata = 32'h0;
    dmem_resp  = 1'b0;
    #12;
    chk("rst_read", 32'(dmem_read), 32'd0);
    chk("rst_write", 32'(dmem_write), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wmask", 32'(dmem_wmask), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_ldata", load_data, 32'h0);
    rst_n = 1'b1;
    step();

    // LW 0x1000, response two cycles after the request appears.
    ex_mem = mk(1'b1, 1'b1, 1'b0, Lw, 32'h0000_1000, 32'h0);
    #1;
    chk("lw_stall_c1", 32'(mem_stall), 32'd1);
    chk("lw_read_c1", 32'(dmem_read), 32'd0);
    chk("lw_misal", 32'(misaligned), 32'd0);
    step();
    chk("lw_stall_c2", 32'(mem_stall), 32'd1);
    chk("lw_read_c2", 32'(dmem_read), 32'd1);
    chk("lw_addr", dmem_addr, 32'h0000_1000);
    chk("lw_write", 32'(dmem_write), 32'd0);
    chk("lw_wmask", 32'(dmem_wmask), 32'h0);
    step();
    chk("lw_stall_c3", 32'(mem_stall), 32'd1);
    chk("lw_read_c3", 32'(dmem_read), 32'd1);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    chk("lw_stall_hold", 32'(mem_stall), 32'd0);
    chk("lw_read_hold", 32'(dmem_read), 32'd0);
    chk("lw_data", load_data, 32'hDEAD_BEEF);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    advance    = 1'b1;
    step();
    ex_mem  = '0;
    advance = 1'b0;
    #1;
    chk("lw_idle_ldata", load_data, 32'h0);
    chk("lw_idle_stall", 32'(mem_stall), 32'd0);

    // Stores.
    store_txn("sb", Sb, 32'h0000_2003, 32'h0000_00A5, 32'h0000_2000, 4'b1000, 32'hA500_0000);
    store_txn("sh", Sh, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_0000);
    store_txn("sw", Sw, 32'h0000_2004, 32'h0BAD_F00D, 32'h0000_2004, 4'b1111, 32'h0BAD_F00D);

    // Load extraction.
    load_txn("lb", Lb, 32'h0000_3002, 32'h12F0_ABCD, 32'h0000_3000, 32'hFFFF_FFF0);
    load_txn("lbu", Lbu, 32'h0000_3002, 32'h12F0_ABCD, 32'h0000_3000, 32'h0000_00F0);
    load_txn("lh", Lh, 32'h0000_3002, 32'h12F0_ABCD, 32'h0000_3000, 32'h0000_12F0);
    load_txn("lh_neg", Lh, 32'h0000_3000, 32'h1234_ABCD, 32'h0000_3000, 32'hFFFF_ABCD);
    load_txn("lhu", Lhu, 32'h0000_3000, 32'h1234_ABCD, 32'h0000_3000, 32'h0000_ABCD);
    load_txn("lb_b1", Lb, 32'h0000_3001, 32'h1234_7FCD, 32'h0000_3000, 32'h0000_007F);

    // Misaligned accesses never issue and never stall.
    ex_mem = mk(1'b1, 1'b1, 1'b0, Lw, 32'h0000_4001, 32'h0);
    #1;
    chk("mis_lw_flag", 32'(misaligned), 32'd1);
    chk("mis_lw_stall", 32'(mem_stall), 32'd0);
    step();
    chk("mis_lw_read", 32'(dmem_read), 32'd0);
    chk("mis_lw_stall2", 32'(mem_stall), 32'd0);
    ex_mem = mk(1'b1, 1'b0, 1'b1, Sh, 32'h0000_4003, 32'h1);
    #1;
    chk("mis_sh_flag", 32'(misaligned), 32'd1);
    step();
    chk("mis_sh_write", 32'(dmem_write), 32'd0);
    ex_mem = mk(1'b1, 1'b1, 1'b0, Lh, 32'h0000_4002, 32'h0);
    #1;
    chk("al_lh_flag", 32'(misaligned), 32'd0);
    chk("al_lh_stall", 32'(mem_stall), 32'd1);
    ex_mem = mk(1'b0, 1'b1, 1'b0, Lw, 32'h0000_4001, 32'h0);
    #1;
    chk("flush_misal", 32'(misaligned), 32'd0);
    // Flushed bundle never issues.
    ex_mem = mk(1'b0, 1'b1, 1'b0, Lw, 32'h0000_5000, 32'h0);
    #1;
    chk("flush_stall", 32'(mem_stall), 32'd0);
    step();
    chk("flush_read", 32'(dmem_read), 32'd0);
    ex_mem = '0;

    // Load completes, then the pipeline stays frozen for five cycles.
    ex_mem = mk(1'b1, 1'b1, 1'b0, Lw, 32'h0000_6000, 32'h0);
    #1;
    step();
    chk("hold_req", 32'(dmem_read), 32'd1);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1122_3344;
    step();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", load_data, 32'h1122_3344);
      chk("hold_read", 32'(dmem_read), 32'd0);
      chk("hold_stall", 32'(mem_stall), 32'd0);
      // A stray response in HOLD must be ignored.
      if (i == 2) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
      end else begin
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
      end
      step();
    end
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    chk("hold_data_end", load_data, 32'h1122_3344);
    advance = 1'b1;
    step();
    ex_mem  = '0;
    advance = 1'b0;
    #1;
    chk("hold_exit_ldata", load_data, 32'h0);
    chk("hold_exit_read", 32'(dmem_read), 32'd0);
    step();
    chk("hold_no_reissue", 32'(dmem_read), 32'd0);

    // Reset pulsed mid-BUSY.
    ex_mem = mk(1'b1, 1'b0, 1'b1, Sw, 32'h0000_7000, 32'hCAFE_BABE);
    #1;
    step();
    chk("rb_write", 32'(dmem_write), 32'd1);
    chk("rb_wdata", dmem_wdata, 32'hCAFE_BABE);
    #2;
    rst_n  = 1'b0;
    ex_mem = '0;
    #1;
    chk("rb_async_write", 32'(dmem_write), 32'd0);
    chk("rb_async_read", 32'(dmem_read), 32'd0);
    chk("rb_async_addr", dmem_addr, 32'h0);
    chk("rb_async_wmask", 32'(dmem_wmask), 32'h0);
    chk("rb_async_wdata", dmem_wdata, 32'h0);
    chk("rb_async_stall", 32'(mem_stall), 32'd0);
    #2;
    rst_n     = 1'b1;
    dmem_resp = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    step();
    chk("rb_late_stall", 32'(mem_stall), 32'd0);
    chk("rb_late_ldata", load_data, 32'h0);
    chk("rb_late_write", 32'(dmem_write), 32'd0);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    step();
    chk("rb_idle_stall", 32'(mem_stall), 32'd0);
    chk("rb_idle_ldata", load_data, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
